// File: rtl/arb_pkg.sv
// Shared types and helpers for the eight-way round-robin arbiter.
// Holds the request count, the index width, the state enum and the rotated priority search.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Returns the first set request at or after 'start', wrapping mod N_REQ.
  // The result is ignored by callers when no request is set.
  function automatic logic [IDX_W-1:0] rr_search(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] start
  );
    logic             found;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] win;
    found = 1'b0;
    win   = start;
    for (int i = 0; i < N_REQ; i++) begin
      pos = start + IDX_W'(i);
      if (!found && req[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable.
// The output is all-zero when the enable is low.
module onehot_dec3
  import arb_pkg::*;
(
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_REQ-1:0] o_onehot
);

  always_comb begin
    // NOTE: assign a default first so every path drives the output and no latch is inferred.
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a bounded hold time.
// It registers a binary grant index and decodes it into a one-hot grant vector.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  localparam int              CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [CNT_W-1:0] r_cnt;

  logic [N_REQ-1:0] w_own_mask;
  logic             w_own_req;
  logic             w_other_req;
  logic [IDX_W-1:0] w_next_ptr;
  logic [IDX_W-1:0] w_idle_win;
  logic [IDX_W-1:0] w_hand_win;
  logic             w_hold;

  assign w_own_mask  = {{(N_REQ-1){1'b0}}, 1'b1} << r_gnt_idx;
  assign w_own_req   = |(req & w_own_mask);
  assign w_other_req = |(req & ~w_own_mask);
  assign w_next_ptr  = r_gnt_idx + IDX_W'(1);
  assign w_idle_win  = rr_search(req, r_ptr);
  // The search from gnt_idx+1 reaches the current grantee last, so any other requester wins first.
  assign w_hand_win  = rr_search(req, w_next_ptr);
  // With en low the grant is never preempted, only released.
  assign w_hold      = w_own_req && ((r_cnt != CNT_MAX) || !w_other_req || !en);

  // NOTE: every state register is cleared by the asynchronous reset, so outputs drop without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      case (r_state)
        IDLE: begin
          if (en && (req != '0)) begin
            r_state   <= BUSY;
            r_gnt_idx <= w_idle_win;
            r_cnt     <= '0;
          end
        end
        BUSY: begin
          if (w_hold) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_ptr <= w_next_ptr;
            if (en && w_other_req) begin
              r_gnt_idx <= w_hand_win;
              r_cnt     <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = (r_state == BUSY);

  onehot_dec3 u_dec (
    .i_en     (gnt_vld),
    .i_idx    (r_gnt_idx),
    .o_onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arb8.sv
// Randomized and directed bench for rr_arb8 against a cycle-level behavioural model.
// The model tracks owner, rotation pointer and cycles held as plain integers.
module tb_rr_arb8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

  int n_vec;
  int n_err;

  // behavioural model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;

  rr_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [11:0] obs = {gnt_vld, gnt_idx, gnt};

  function automatic int m_search(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return start;
  endfunction

  function automatic logic [11:0] exp_out();
    logic [7:0] g;
    g = m_busy ? (8'd1 << m_owner) : 8'd0;
    return {m_busy, 3'(m_owner), g};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  // Applies the arbitration rules to the inputs sampled at this edge.
  task automatic model_step();
    logic [7:0] others;
    if (!m_busy) begin
      if (en && req != 8'd0) begin
        m_busy  = 1'b1;
        m_owner = m_search(req, m_ptr);
        m_held  = 0;
      end
    end else begin
      m_held = m_held + 1;
      others = req & ~(8'd1 << m_owner);
      if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % 8;
        if (en && others != 8'd0) begin
          m_owner = m_search(req, m_ptr);
          m_held  = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else if (en && others != 8'd0 && m_held >= MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = m_search(req, m_ptr);
        m_held  = 0;
      end
    end
  endtask

  // Advances one clock, updates the model and leaves time 1 unit past the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 8'd0;
    en    = 1'b1;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (obs !== 12'h000) begin
        n_err++;
        $display("FAIL reset_hold: got %h want %h", obs, 12'h000);
      end
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (gnt !== 8'h01 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL reset_first_grant: got gnt %h want 01 (model %h obs %h)", gnt, exp_out(), obs);
    end
  endtask

  // Continues from test_reset: grant on 0 was issued at the previous edge.
  task automatic test_round_robin();
    for (int j = 1; j <= 36; j++) begin
      step();
      n_vec++;
      if (gnt_vld !== 1'b1 || int'(gnt_idx) != (j / MAX_HOLD) % 8 || obs !== exp_out()) begin
        n_err++;
        $display("FAIL round_robin[%0d]: got vld %b idx %0d want idx %0d", j, gnt_vld, gnt_idx,
                 (j / MAX_HOLD) % 8);
      end
    end
  endtask

  task automatic test_release_handoff();
    logic [7:0] seq_req [3] = '{8'h05, 8'h04, 8'h00};
    logic [7:0] seq_gnt [3] = '{8'h01, 8'h04, 8'h00};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req = seq_req[i];
      step();
      n_vec++;
      if (gnt !== seq_gnt[i] || obs !== exp_out()) begin
        n_err++;
        $display("FAIL release_handoff[%0d]: got gnt %h want %h", i, gnt, seq_gnt[i]);
      end
    end
  endtask

  task automatic test_sole_requester();
    req = 8'h10;
    for (int i = 0; i < 100; i++) begin
      step();
      n_vec++;
      if (gnt !== 8'h10 || obs !== exp_out()) begin
        n_err++;
        $display("FAIL sole_requester[%0d]: got gnt %h want 10", i, gnt);
      end
    end
    // Saturated hold count: a new waiter forces a preempt at the next edge.
    req = 8'h11;
    step();
    n_vec++;
    if (gnt !== 8'h01 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL sole_preempt: got gnt %h want 01", gnt);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_en_gating();
    apply_reset();
    en  = 1'b0;
    req = 8'h03;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (gnt !== 8'h00 || obs !== exp_out()) begin
        n_err++;
        $display("FAIL en_idle[%0d]: got gnt %h want 00", i, gnt);
      end
    end
    en  = 1'b1;
    req = 8'h02;
    step();
    en  = 1'b0;
    req = 8'h03;
    step();
    n_vec++;
    if (gnt !== 8'h02 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL en_hold: got gnt %h want 02", gnt);
    end
    req = 8'h01;
    step();
    n_vec++;
    if (gnt !== 8'h00 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL en_release: got gnt %h want 00", gnt);
    end
    en = 1'b1;
    step();
    n_vec++;
    if (gnt !== 8'h01 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL en_resume: got gnt %h want 01", gnt);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 8'h20;
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs !== 12'h000) begin
      n_err++;
      $display("FAIL async_reset_immediate: got %h want 000", obs);
    end
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (gnt !== 8'h20 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL async_reset_regrant: got gnt %h want 20", gnt);
    end
    // Release moves ptr to 6; a second reset must bring it back to 0.
    req = 8'h00;
    step();
    req = 8'h08;
    step();
    #2 rst_n = 1'b0;
    model_reset();
    req = 8'h41;
    step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (gnt !== 8'h01 || obs !== exp_out()) begin
      n_err++;
      $display("FAIL async_reset_ptr: got gnt %h want 01", gnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      en = ($urandom_range(0, 7) != 0);
      step();
      n_vec++;
      if (obs !== exp_out()) begin
        n_err++;
        $display("FAIL random[%0d]: req %h en %b got %h want %h", i, req, en, obs, exp_out());
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    model_reset();
    test_reset();
    test_round_robin();
    test_release_handoff();
    test_sole_requester();
    test_en_gating();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
